// File: rtl/shift_frame_sequencer.sv
// shift_frame_sequencer: accepts a parallel word and shifts it out MSB first, one bit per falling edge.
// Defining SHIFT_PARITY_EN appends an even-parity trailer bit to every frame.
module shift_frame_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [1:0]       state_dbg
);

`ifdef SHIFT_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(FL + 1);
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             tx_bit;
  logic             accept;
  logic             advance;

  // Handshake: a word transfers on a falling edge where load_valid && load_ready;
  // load_ready depends on state only, so the producer may hold valid and data
  // steady for as long as it likes, and load_data is ignored outside that edge.
  assign accept  = load_valid && load_ready;
  assign advance = (state == SHIFT) && !hold;

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (advance && (cnt == LAST)) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= load_data;
      cnt <= '0;
    end else if (advance) begin
      sr  <= {sr[WIDTH-2:0], 1'b0};
      cnt <= cnt + CW'(1);
    end
  end

`ifdef SHIFT_PARITY_EN
  logic par;

  // Parity accumulates as data bits leave, so it is complete when cnt reaches WIDTH.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= 1'b0;
    end else if (advance && (cnt < CW'(WIDTH))) begin
      par <= par ^ sr[WIDTH-1];
    end
  end

  assign tx_bit = (cnt == CW'(WIDTH)) ? par : sr[WIDTH-1];
`else
  assign tx_bit = sr[WIDTH-1];
`endif

  always_comb begin
    load_ready = 1'b1;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      SHIFT: begin
        load_ready = 1'b0;
        ser_out    = tx_bit;
        ser_valid  = 1'b1;
        busy       = 1'b1;
      end
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: doc/shift_frame_sequencer.md
# shift_frame_sequencer

Controller that sequences a WIDTH-bit shift register built from the team's negative-edge D flip-flops. It accepts a parallel word over a valid/ready handshake and shifts it out serially, MSB first, one bit per clock. It then signals frame completion. It sits between a parallel producer and any serial consumer, such as a display driver or bit-serial link, in the flip-flop-based lab designs.

## Interface
- WIDTH, 4, data word width; legal range 2..16.
- clk  input  1  system clock; all state changes on the falling edge.
- reset_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  producer has a word on load_data.
- load_data  input  WIDTH  parallel word to transmit.
- load_ready  output  1  sequencer can accept a word this cycle.
- hold  input  1  freeze shifting while high; SHIFT state only.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a frame bit.
- busy  output  1  a frame is in progress (SHIFT state).
- frame_done  output  1  one-cycle pulse after the last frame bit.

Decided: one clock; reset is asynchronous and active-low, ports clk and reset_n.

## Operation
- States: IDLE, SHIFT, DONE.
- Frame length FL = WIDTH (+1 when parity is enabled, see Configuration).
- Registered internal state:
  - shift register sr[WIDTH-1:0]
  - bit counter cnt, ceil(log2(FL+1)) bits
  - parity accumulator
- Reset values (asynchronous, immediate):
  - state IDLE, sr 0, cnt 0
  - ser_out 0, ser_valid 0, busy 0, frame_done 0, load_ready 1
- IDLE:
  - load_ready=1.
  - Accept occurs on a falling edge with load_valid&load_ready: sr<=load_data, cnt<=0, go to SHIFT.
- SHIFT:
  - ser_out=sr[WIDTH-1], ser_valid=1, busy=1, load_ready=0.
  - Each falling edge with hold=0: sr<=sr<<1 (LSB filled 0), cnt<=cnt+1.
  - When cnt==FL-1 and hold=0, go to DONE instead.
  - With hold=1: sr, cnt and ser_out unchanged; ser_valid stays 1.
- DONE:
  - frame_done=1, ser_valid=0, ser_out=0, busy=0, load_ready=1.
  - Next falling edge: go to SHIFT if a word is accepted (back-to-back), else go to IDLE.
- hold is ignored in IDLE and DONE.
- load_valid is ignored whenever load_ready=0. A word presented during SHIFT is not captured.
- load_data is sampled only at the accept edge. Later changes have no effect on the frame.

## Timing
- All outputs are registered, or decoded from state only, and change only after a falling clk edge or reset_n assertion.
- Latency: the first bit (MSB) appears on ser_out directly after the accept edge, with zero idle cycles.
- Frame timing with hold low throughout:
  - FL ser_valid cycles, then one frame_done cycle.
  - Throughput is FL+1 cycles per word with back-to-back loads.
- Each hold cycle extends the frame by exactly one cycle.
- Reset mid-frame discards the frame. frame_done does not pulse for it. Outputs return to reset values without waiting for a clock edge.
- Release of reset_n takes effect at the first falling edge after deassertion.

## Configuration
- SHIFT_PARITY_EN defined:
  - FL=WIDTH+1.
  - After the WIDTH data bits, SHIFT presents one extra bit equal to the XOR of the accepted word (even parity), with ser_valid=1.
  - That bit obeys hold like the data bits.
- SHIFT_PARITY_EN undefined: FL=WIDTH, no parity logic is present, and frame_done follows the LSB directly.

## Test plan
- Reset values:
  - Stimulus: assert reset_n=0 mid-simulation with random inputs.
  - Required: immediately ser_out=0, ser_valid=0, busy=0, frame_done=0, load_ready=1.
- Basic frame (WIDTH=4, no macro):
  - Stimulus: accept 4'b1011.
  - Required: ser_out 1,0,1,1 on four consecutive cycles with ser_valid=1 and busy=1, then frame_done=1 for exactly one cycle, then IDLE.
- Hold:
  - Stimulus: accept 4'b1100, raise hold for 3 cycles while bit 1 is shown.
  - Required: ser_out stays 1 for 4 cycles total, the frame lasts 7 valid cycles, and the bit order is unchanged.
- Back-to-back:
  - Stimulus: hold load_valid high with 4'b1001, then 4'b0110 presented during DONE.
  - Required: ser_out 1,0,0,1, then a DONE cycle, then 0,1,1,0.
  - Required: no word is captured during SHIFT.
- Reset mid-frame:
  - Stimulus: assert reset_n after 2 bits of 4'b1111.
  - Required: outputs reset instantly and no frame_done pulse.
  - Required: after release, a new 4'b0001 transmits cleanly.
- Parity (SHIFT_PARITY_EN defined):
  - Stimulus: accept 4'b1011.
  - Required: ser_out 1,0,1,1,1 (parity 1) over 5 valid cycles, then frame_done.
  - Stimulus: accept 4'b0011.
  - Required: parity bit 0.
